tx_qam_src: RTL and testbench

TX_QAM_SRC -- requirements
Module: tx_qam_src

---
 rtl/tx_qam_src.sv | 110 +++++++++++
 tb/tb_tx_qam_src.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_qam_src.sv
// PRBS9-driven QPSK / 16-QAM baseband symbol source with a valid/ready output
// handshake, a synchronous re-seed/flush and an accepted-symbol counter.
module tx_qam_src #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [8:0]  SEED       = 9'h1FF,
  parameter int          QPSK_AMP   = 23170,
  parameter int          QAM_LVL    = 7327,
  parameter int          CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         sync_clr,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] tx_i,
  output logic signed [DATA_WIDTH-1:0] tx_q,
  output logic        [CNT_W-1:0]      sym_cnt
);

  if (SEED == 9'd0) begin : g_bad_seed
    $error("tx_qam_src: SEED must be non-zero");
  end
  if (3 * QAM_LVL >= (1 << (DATA_WIDTH - 1))) begin : g_bad_lvl
    $error("tx_qam_src: 3*QAM_LVL does not fit in DATA_WIDTH");
  end

  localparam logic signed [DATA_WIDTH-1:0] AMP  = DATA_WIDTH'(QPSK_AMP);
  localparam logic signed [DATA_WIDTH-1:0] LVL1 = DATA_WIDTH'(QAM_LVL);
  localparam logic signed [DATA_WIDTH-1:0] LVL3 = DATA_WIDTH'(3 * QAM_LVL);

  // Gray-coded 16-QAM axis level: sign from the first bit, magnitude from the second.
  function automatic logic signed [DATA_WIDTH-1:0] qam_level(input logic sgn, input logic mag);
    case ({sgn, mag})
      2'b00:   qam_level = LVL3;
      2'b01:   qam_level = LVL1;
      2'b11:   qam_level = -LVL1;
      default: qam_level = -LVL3;
    endcase
  endfunction

  logic [8:0]                   lfsr;
  logic [8:0]                   lfsr_nxt;
  logic [8:0]                   stage [4];
  logic [3:0]                   bits;
  logic signed [DATA_WIDTH-1:0] sym_i;
  logic signed [DATA_WIDTH-1:0] sym_q;
  logic                         gen;
  logic                         acc;

  assign acc = out_valid && out_ready;
  assign gen = en && !sync_clr && (!out_valid || out_ready);

  // Unroll four LFSR steps; QPSK simply stops after the second.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic [8:0] s;
    s = lfsr;
    bits = '0;
    for (int k = 0; k < 4; k++) begin
      bits[k]  = s[8] ^ s[4];
      s        = {s[7:0], bits[k]};
      stage[k] = s;
    end
    lfsr_nxt = mode ? stage[3] : stage[1];
  end

  always_comb begin
    sym_i = '0;
    sym_q = '0;
    if (mode) begin
      sym_i = qam_level(bits[0], bits[1]);
      sym_q = qam_level(bits[2], bits[3]);
    end else begin
      sym_i = bits[0] ? -AMP : AMP;
      sym_q = bits[1] ? -AMP : AMP;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      out_valid <= 1'b0;
      tx_i      <= '0;
      tx_q      <= '0;
      sym_cnt   <= '0;
    end else if (sync_clr) begin
      lfsr      <= SEED;
      out_valid <= 1'b0;
      tx_i      <= '0;
      tx_q      <= '0;
      sym_cnt   <= '0;
    end else begin
      if (acc) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
      if (gen) begin
        lfsr      <= lfsr_nxt;
        tx_i      <= sym_i;
        tx_q      <= sym_q;
        out_valid <= 1'b1;
      end else if (acc) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_qam_src.sv
// Self-checking bench for tx_qam_src: fixed vector table, randomized run against
// a bit-stream reference model, and directed handshake/reset/wrap sequences.
module tb_tx_qam_src;

  localparam int A  = 23170;
  localparam int L  = 7327;
  localparam int NB = 30000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        sync_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_valid4;
  logic signed [15:0] tx_i, tx_q, tx_i4, tx_q4;
  logic [15:0] sym_cnt;
  logic [3:0]  sym_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_qam_src dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sync_clr(sync_clr),
    .out_ready(out_ready), .out_valid(out_valid), .tx_i(tx_i), .tx_q(tx_q),
    .sym_cnt(sym_cnt)
  );

  tx_qam_src #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sync_clr(sync_clr),
    .out_ready(out_ready), .out_valid(out_valid4), .tx_i(tx_i4), .tx_q(tx_q4),
    .sym_cnt(sym_cnt4)
  );

  // PRBS9 as a plain recurrence on the emitted bit stream: x[n] = x[n-9] ^ x[n-5],
  // with x[-9..-1] taken from the seed, MSB first.
  bit prbs [NB + 9];
  int ptr;
  int m_valid, m_i, m_q, m_cnt;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qpsk(input bit b);
    return b ? -A : A;
  endfunction

  function automatic int qam(input bit b0, input bit b1);
    return (b0 ? -1 : 1) * (b1 ? 1 : 3) * L;
  endfunction

  task automatic model_clear();
    ptr = 0; m_valid = 0; m_i = 0; m_q = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit g, a;
    if (sync_clr) begin
      model_clear();
      return;
    end
    g = en && (m_valid == 0 || out_ready);
    a = (m_valid != 0) && out_ready;
    if (a) m_cnt++;
    if (g) begin
      if (ptr + 4 > NB) begin
        check("prbs_buffer", ptr, 0);
        ptr = 0;
      end
      if (mode) begin
        m_i = qam(prbs[ptr+9], prbs[ptr+10]);
        m_q = qam(prbs[ptr+11], prbs[ptr+12]);
        ptr += 4;
      end else begin
        m_i = qpsk(prbs[ptr+9]);
        m_q = qpsk(prbs[ptr+10]);
        ptr += 2;
      end
      m_valid = 1;
    end else if (a) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_valid"}, out_valid, m_valid);
    check({tag, "_i"}, tx_i, m_i);
    check({tag, "_q"}, tx_q, m_q);
    check({tag, "_cnt"}, sym_cnt, m_cnt % 65536);
    check({tag, "_cnt4"}, sym_cnt4, m_cnt % 16);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input bit e, input bit m, input bit r, input bit c);
    en = e; mode = m; out_ready = r; sync_clr = c;
  endtask

  typedef struct {
    bit en, mode, rdy, clr;
    bit exp_valid;
    int exp_i, exp_q, exp_cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int k = 0; k < 9; k++) prbs[k] = 1'b1;
    for (int k = 9; k < NB + 9; k++) prbs[k] = prbs[k-9] ^ prbs[k-5];

    // Bits from the default seed start 0,0,0,0,0,1,1,1,1,...
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A, A, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, A, A, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3*L, L, 1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3*L, L, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -A, -A, 2};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3*L, 3*L, 0};

    // Reset state
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_i", tx_i, 0);
    check("rst_q", tx_q, 0);
    check("rst_cnt", sym_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", out_valid, 0);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].en, vecs[v].mode, vecs[v].rdy, vecs[v].clr);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", v), out_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_i", v), tx_i, vecs[v].exp_i);
      check($sformatf("vec%0d_q", v), tx_q, vecs[v].exp_q);
      check($sformatf("vec%0d_cnt", v), sym_cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_cnt4", v), sym_cnt4, vecs[v].exp_cnt);
    end

    // Align model with a flush, then randomized run
    drive(0, 0, 0, 1);
    cycle("flush");
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 9) < 7,
            $urandom_range(0, 199) == 0);
      cycle("rand");
    end

    // QPSK: first symbol and period-511 repeat at symbol 512
    drive(0, 0, 1, 1);
    cycle("q_clr");
    drive(1, 0, 1, 0);
    for (int s = 1; s <= 512; s++) begin
      cycle("qpsk");
      if (s == 1 || s == 512) begin
        check($sformatf("qpsk_sym%0d_i", s), tx_i, A);
        check($sformatf("qpsk_sym%0d_q", s), tx_q, A);
      end
    end

    // 16-QAM: first symbol and constellation membership
    drive(0, 1, 1, 1);
    cycle("m_clr");
    drive(1, 1, 1, 0);
    for (int s = 1; s <= 100; s++) begin
      cycle("qam");
      if (s == 1) begin
        check("qam_first_i", tx_i, 3*L);
        check("qam_first_q", tx_q, 3*L);
      end
      check("qam_in_set",
            ((tx_i == L || tx_i == -L || tx_i == 3*L || tx_i == -3*L) &&
             (tx_q == L || tx_q == -L || tx_q == 3*L || tx_q == -3*L)), 1);
    end

    // Stall 10 cycles with en toggling and mode flipping; outputs must hold
    begin
      int hi, hq, hc;
      hi = m_i; hq = m_q; hc = m_cnt;
      for (int s = 0; s < 10; s++) begin
        drive(s % 2, s % 3 == 0, 0, 0);
        cycle("stall");
      end
      check("stall_i", tx_i, hi);
      check("stall_q", tx_q, hq);
      check("stall_cnt", sym_cnt, hc);
      drive(1, 0, 1, 0);
      for (int s = 0; s < 5; s++) cycle("resume");
    end

    // en low for 10 cycles: last symbol accepted, valid drops, then resumes
    drive(0, 0, 1, 0);
    for (int s = 0; s < 10; s++) cycle("en_off");
    check("en_off_valid", out_valid, 0);
    drive(1, 0, 1, 0);
    for (int s = 0; s < 5; s++) cycle("en_on");

    // sync_clr mid-stream
    drive(1, 0, 1, 1);
    cycle("sclr");
    check("sclr_cnt", sym_cnt, 0);
    check("sclr_valid", out_valid, 0);
    drive(1, 0, 1, 0);
    cycle("sclr_first");
    check("sclr_first_i", tx_i, A);
    check("sclr_first_q", tx_q, A);
    for (int s = 0; s < 7; s++) cycle("sclr_run");

    // Asynchronous reset mid-stream, sampled between edges
    drive(1, 1, 1, 0);
    for (int s = 0; s < 5; s++) cycle("pre_rst");
    rst_n = 1'b0;
    #1;
    model_clear();
    compare_model("arst");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_step();
    compare_model("arst_first");
    check("arst_first_i", tx_i, 3*L);
    check("arst_first_q", tx_q, 3*L);

    // CNT_W=4 wrap: 20 acceptances
    drive(0, 0, 1, 1);
    cycle("w_clr");
    drive(1, 0, 1, 0);
    for (int s = 0; s < 40 && m_cnt < 20; s++) cycle("wrap");
    check("wrap_cnt4", sym_cnt4, 4);
    check("wrap_cnt16", sym_cnt, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
